led_stripe_receiver: RTL and testbench
======================================

LED_STRIPE_RECEIVER -- requirements
Module: led_stripe_receiver

Interface
REQ-001 Parameter T_MIN_CYCLES, default 8: shortest legal high pulse, in clk cycles.
REQ-002 Parameter T_THRESH_CYCLES, default 30: a high width >= this decodes as 1, otherwise 0.
REQ-003 Parameter T_MAX_HIGH_CYCLES, default 100: longest legal high pulse.
REQ-004 Parameter T_RESET_CYCLES, default 2500: low time that marks the frame-reset gap.
REQ-005 Clock and reset: one clock; reset is synchronous and active-low.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 rstn  input  1  synchronous active-low reset.
REQ-008 led_stripe_pin  input  1  asynchronous single-wire NRZ LED-stripe data line.
REQ-009 pixel_data  output  24  last complete pixel, first received bit in bit 23.
REQ-010 pixel_valid  output  1  one-cycle pulse; pixel_data is new in the same cycle.
REQ-011 pixel_count  output  8  pixels received in the current frame, saturating at 255.
REQ-012 frame_end  output  1  one-cycle pulse on a reset gap that follows at least one decoded bit.
REQ-013 bit_error  output  1  one-cycle pulse on a protocol violation.

Function
REQ-014 led_stripe_pin SHALL pass a 2-flop synchronizer; edges are detected on the synchronized value (edge-to-decision latency 3 cycles).
REQ-015 FSM states: SYNC, WAIT_HIGH, MEAS_HIGH; 16-bit saturating width counter; 5-bit bit counter; 24-bit shift register.
REQ-016 SYNC: count consecutive low cycles; at count == T_RESET_CYCLES go to WAIT_HIGH; a high sample clears the count, so line activity mid-frame is never decoded.
REQ-017 WAIT_HIGH: count low cycles; on rising edge go to MEAS_HIGH with counter = 1.
REQ-018 WAIT_HIGH, low count reaching T_RESET_CYCLES: pulse frame_end if any bit was decoded since the last frame_end; clear bit counter, partial pixel and pixel_count; stay in WAIT_HIGH.
REQ-019 MEAS_HIGH, falling edge with width w: shift bit (w >= T_THRESH_CYCLES) in MSB-first; go to WAIT_HIGH.
REQ-020 On the 24th bit: pixel_data <= assembled word and pixel_valid = 1 in the cycle after the decision; pixel_count increments (saturating); bit counter wraps to 0.
REQ-021 Simultaneous frame_end and pixel_valid are impossible; a gap with 1-23 bits pending discards them silently.

Reset
REQ-022 rstn low: state = SYNC, counters = 0, pixel_data = 0, pixel_count = 0, pixel_valid = frame_end = bit_error = 0, synchronizer flops = 0.
REQ-023 Reset asserted mid-pixel discards the partial pixel; after release a full reset gap is required before decoding.

Configuration
REQ-024 Macro LED_STRIPE_RX_ERR_EN defined: w < T_MIN_CYCLES, or a high lasting > T_MAX_HIGH_CYCLES, pulses bit_error for one cycle, discards the partial pixel, clears pixel_count and enters SYNC.
REQ-025 Macro undefined: no width checks; every high pulse is decoded; the width counter saturates on a stuck-high line; bit_error is tied to 0.

Structure
REQ-026 Shared package led_stripe_pkg: FSM state enum, 16-bit counter width constant, 24-bit pixel width constant, default timing constants (also used by the transmitter).
REQ-027 One sub-module, led_stripe_rx_sync: 2-flop synchronizer plus rise/fall pulse outputs.

Verification
REQ-028 2500 low, then 24 pulses of 40 high / 22 low -> one pixel_valid, pixel_data = 24'hFFFFFF, pixel_count = 1.
REQ-029 After the gap, alternating 40/20 high pulses starting with 40, each followed by 25 low, then 2500 low -> pixel_data = 24'hAAAAAA, then frame_end one cycle after low count hits 2500.
REQ-030 No initial gap; 24 valid pulses sent immediately after reset -> no pixel_valid and no frame_end.
REQ-031 3 pixels, then 12 bits, then gap -> pixel_count = 3 before the gap, one frame_end, no 4th pixel_valid, pixel_count = 0 afterwards.
REQ-032 With LED_STRIPE_RX_ERR_EN: a 4-cycle high pulse -> bit_error pulse, SYNC entered; 150-cycle high -> bit_error; without the macro, same stimulus -> bit_error stays 0.
REQ-033 rstn pulsed low after bit 10 of a pixel -> all outputs 0, next 24 bits after a fresh gap yield a correct pixel.

Source files
------------

// File: rtl/led_stripe_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_stripe_pkg : shared types and timing defaults for the LED-stripe link
// Rev 1.0
// ---------------------------------------------------------------------------
package led_stripe_pkg;

  typedef enum logic [1:0] {
    SYNC      = 2'd0,
    WAIT_HIGH = 2'd1,
    MEAS_HIGH = 2'd2
  } rx_state_t;

  localparam int CNT_W   = 16;
  localparam int PIXEL_W = 24;

  localparam int T_MIN_DEFAULT      = 8;
  localparam int T_THRESH_DEFAULT   = 30;
  localparam int T_MAX_HIGH_DEFAULT = 100;
  localparam int T_RESET_DEFAULT    = 2500;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_stripe_rx_sync.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_stripe_rx_sync : 2-flop synchronizer with rise/fall pulses
// Rev 1.0
// ---------------------------------------------------------------------------
module led_stripe_rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta, sync, prev;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule
`default_nettype wire

// File: rtl/led_stripe_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// led_stripe_receiver : NRZ single-wire LED-stripe decoder, 24-bit pixels.
// LED_STRIPE_RX_ERR_EN enables pulse-width checking and bit_error.
// Rev 1.0
// ---------------------------------------------------------------------------
module led_stripe_receiver
  import led_stripe_pkg::*;
#(
  parameter int T_MIN_CYCLES      = T_MIN_DEFAULT,
  parameter int T_THRESH_CYCLES   = T_THRESH_DEFAULT,
  parameter int T_MAX_HIGH_CYCLES = T_MAX_HIGH_DEFAULT,
  parameter int T_RESET_CYCLES    = T_RESET_DEFAULT
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               led_stripe_pin,
  output logic [PIXEL_W-1:0] pixel_data,
  output logic               pixel_valid,
  output logic [7:0]         pixel_count,
  output logic               frame_end,
  output logic               bit_error
);

`ifdef LED_STRIPE_RX_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(T_MIN_CYCLES);
  localparam logic [CNT_W-1:0] THRESH_W = CNT_W'(T_THRESH_CYCLES);
  localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(T_MAX_HIGH_CYCLES);
  localparam logic [CNT_W-1:0] RESET_W  = CNT_W'(T_RESET_CYCLES);
  localparam logic [4:0]       LAST_BIT = 5'(PIXEL_W - 1);

  logic sync_level, sync_rise, sync_fall;

  led_stripe_rx_sync u_sync (
    .clk   (clk),
    .rstn  (rstn),
    .din   (led_stripe_pin),
    .level (sync_level),
    .rise  (sync_rise),
    .fall  (sync_fall)
  );

  rx_state_t          state;
  logic [CNT_W-1:0]   width_cnt;
  logic [4:0]         bit_cnt;
  logic [PIXEL_W-2:0] shift_reg;
  logic               bits_seen;
  logic               bit_val, too_short, too_long;

  assign bit_val   = (width_cnt >= THRESH_W);
  assign too_short = ERR_EN && sync_fall && (width_cnt < MIN_W);
  // Still high with the count already at the limit: the pulse is overlong.
  assign too_long  = ERR_EN && !sync_fall && (width_cnt >= MAX_W);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= SYNC;
      width_cnt   <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      bits_seen   <= 1'b0;
      pixel_data  <= '0;
      pixel_valid <= 1'b0;
      pixel_count <= '0;
      frame_end   <= 1'b0;
      bit_error   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_end   <= 1'b0;
      bit_error   <= 1'b0;
      case (state)
        SYNC: begin
          if (sync_level) begin
            width_cnt <= '0;
          end else if (sat_inc(width_cnt) == RESET_W) begin
            state     <= WAIT_HIGH;
            width_cnt <= RESET_W;
          end else begin
            width_cnt <= sat_inc(width_cnt);
          end
        end
        WAIT_HIGH: begin
          if (sync_rise) begin
            state     <= MEAS_HIGH;
            width_cnt <= CNT_W'(1);
          end else if (width_cnt != RESET_W) begin
            width_cnt <= width_cnt + 1'b1;
            // Count parks at RESET_W, so a long idle line flags the gap once.
            if (width_cnt + 1'b1 == RESET_W) begin
              frame_end   <= bits_seen;
              bits_seen   <= 1'b0;
              bit_cnt     <= '0;
              shift_reg   <= '0;
              pixel_count <= '0;
            end
          end
        end
        MEAS_HIGH: begin
          if (too_short || too_long) begin
            bit_error   <= 1'b1;
            state       <= SYNC;
            width_cnt   <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            bits_seen   <= 1'b0;
            pixel_count <= '0;
          end else if (sync_fall) begin
            state     <= WAIT_HIGH;
            width_cnt <= CNT_W'(1);
            bits_seen <= 1'b1;
            if (bit_cnt == LAST_BIT) begin
              pixel_data  <= {shift_reg, bit_val};
              pixel_valid <= 1'b1;
              bit_cnt     <= '0;
              shift_reg   <= '0;
              if (pixel_count != 8'hFF) pixel_count <= pixel_count + 8'd1;
            end else begin
              shift_reg <= {shift_reg[PIXEL_W-3:0], bit_val};
              bit_cnt   <= bit_cnt + 5'd1;
            end
          end else begin
            width_cnt <= sat_inc(width_cnt);
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_led_stripe_receiver.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_led_stripe_receiver : directed + randomized bench with a bit-level model
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_led_stripe_receiver;

`ifdef LED_STRIPE_RX_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        pin = 1'b0;
  logic [23:0] pixel_data;
  logic        pixel_valid;
  logic [7:0]  pixel_count;
  logic        frame_end;
  logic        bit_error;

  always #5 clk = ~clk;

  led_stripe_receiver dut (
    .clk            (clk),
    .rstn           (rstn),
    .led_stripe_pin (pin),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .pixel_count    (pixel_count),
    .frame_end      (frame_end),
    .bit_error      (bit_error)
  );

  int total = 0;
  int bad   = 0;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Observed events
  logic [23:0] obs_q[$];
  int          fe_cnt = 0, be_cnt = 0, both_cnt = 0;
  int unsigned fe_cyc = 0;
  int unsigned last_fall = 0;

  always @(negedge clk) begin
    if (pixel_valid) obs_q.push_back(pixel_data);
    if (frame_end) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (bit_error) be_cnt <= be_cnt + 1;
    if (pixel_valid && frame_end) both_cnt <= both_cnt + 1;
  end

  // Reference model: protocol state in terms of bits and frames
  bit          m_synced = 1'b0;
  int          m_bits   = 0;
  logic [23:0] m_word   = '0;
  int          m_pix    = 0;
  bit          m_any    = 1'b0;
  logic [23:0] exp_q[$];
  int          exp_fe = 0, exp_be = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int n);
    @(negedge clk);
    if (pin && !v) last_fall = cyc;
    pin = v;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic model_clear();
    m_bits = 0; m_word = '0; m_pix = 0; m_any = 1'b0;
  endtask

  task automatic pulse(input int w, input int lo);
    hold(1'b1, w);
    hold(1'b0, lo);
    if (m_synced) begin
      if (ERR && (w < 8 || w > 100)) begin
        exp_be++;
        m_synced = 1'b0;
        model_clear();
      end else begin
        m_word = {m_word[22:0], (w >= 30)};
        m_bits++;
        m_any = 1'b1;
        if (m_bits == 24) begin
          exp_q.push_back(m_word);
          m_bits = 0;
          if (m_pix < 255) m_pix++;
        end
      end
    end
  endtask

  task automatic send_bit(input bit b);
    int w;
    w = b ? int'($urandom_range(60, 30)) : int'($urandom_range(29, 8));
    pulse(w, int'($urandom_range(40, 8)));
  endtask

  task automatic gap();
    hold(1'b0, 2530);
    if (m_synced && m_any) exp_fe++;
    m_synced = 1'b1;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    check({tag, "_npix"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_pix"}, obs_q.pop_front(), exp_q.pop_front());
    obs_q.delete();
    exp_q.delete();
    check({tag, "_fe"}, fe_cnt, exp_fe);
    check({tag, "_be"}, be_cnt, exp_be);
    check({tag, "_cnt"}, pixel_count, m_pix);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_data"}, pixel_data, 0);
    check({tag, "_valid"}, pixel_valid, 0);
    check({tag, "_count"}, pixel_count, 0);
    check({tag, "_fe"}, frame_end, 0);
    check({tag, "_be"}, bit_error, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_idle("reset");
    rstn = 1'b1;

    // Pulses with no preceding gap are never decoded
    hold(1'b0, 20);
    for (int i = 0; i < 24; i++) pulse(40, 22);
    hold(1'b0, 30);
    check("nogap_valid", obs_q.size(), 0);
    check("nogap_fe", fe_cnt, 0);
    check_all("nogap");

    // All-ones pixel
    gap();
    for (int i = 0; i < 24; i++) pulse(40, 22);
    hold(1'b0, 10);
    check("ones_data", pixel_data, 24'hFFFFFF);
    check("ones_count", pixel_count, 1);
    check_all("ones");

    // Alternating pixel then frame gap with exact frame_end timing
    for (int i = 0; i < 24; i++) pulse((i % 2 == 0) ? 40 : 20, 25);
    hold(1'b0, 10);
    check("alt_data", pixel_data, 24'hAAAAAA);
    gap();
    check("alt_fe_delay", fe_cyc - last_fall, 2502);
    check_all("alt");

    // Three random pixels plus a partial one, discarded by the gap
    for (int i = 0; i < 3 * 24 + 12; i++) send_bit(1'($urandom));
    hold(1'b0, 10);
    check("partial_count", pixel_count, 3);
    check_all("partial_pre");
    gap();
    check("partial_count_after", pixel_count, 0);
    check_all("partial_post");

    // Out-of-range pulse widths
    pulse(4, 30);
    hold(1'b0, 10);
    check("short_be", be_cnt, ERR ? 1 : 0);
    check_all("short");
    gap();
    pulse(150, 30);
    hold(1'b0, 10);
    check("long_be", be_cnt, ERR ? 2 : 0);
    check_all("long");
    gap();
    check_all("width_post");

    // Reset mid-pixel
    for (int i = 0; i < 10; i++) send_bit(1'($urandom));
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    check_idle("midrst");
    rstn = 1'b1;
    m_synced = 1'b0;
    model_clear();
    gap();
    for (int i = 0; i < 24; i++) send_bit(1'($urandom));
    hold(1'b0, 10);
    check_all("postrst");

    // Random frame
    for (int i = 0; i < 2 * 24 + 5; i++) send_bit(1'($urandom));
    gap();
    check_all("rand");

    check("no_overlap", both_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
